wb_rr_arbiter: RTL
==================

# wb_rr_arbiter

Parametrised N-master to 1-slave Wishbone classic arbiter with round-robin grant, cycle locking, and a bus-timeout error path. It sits between the core's instruction/data ports (plus any future masters) and the shared memory/peripheral slave. It generalises the single-point Wishbone link to multiple masters and adds the `err` signal that the plain link lacks.

## Interface
- `NUM_MASTERS`, 2: number of master ports, ≥1.
- `ADDR_WIDTH`, 32: `wb_adr` width.
- `DATA_WIDTH`, 32: `wb_datwr`/`wb_datrd` width.
- `SEL_WIDTH`, `DATA_WIDTH/8`: `wb_sel` width.
- `TIMEOUT_CYCLES`, 255: stall cycles before the arbiter forces an error; 0 disables the timeout.

Ports. `N` = `NUM_MASTERS`. Master buses are flattened, with master i in slice i.
- `clock` input 1: the single clock; all state is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `m_wb_adr` input N*ADDR_WIDTH: master addresses.
- `m_wb_datwr` input N*DATA_WIDTH: master write data.
- `m_wb_we`, `m_wb_stb`, `m_wb_cyc` input N each: master controls.
- `m_wb_sel` input N*SEL_WIDTH: master byte selects.
- `m_wb_datrd` output DATA_WIDTH: slave read data, broadcast to all masters.
- `m_wb_ack`, `m_wb_err` output N each: per-master termination.
- `s_wb_adr`, `s_wb_datwr`, `s_wb_we`, `s_wb_stb`, `s_wb_cyc`, `s_wb_sel` output: slave side, same widths as one master slice.
- `s_wb_datrd` input DATA_WIDTH, `s_wb_ack` input 1, `s_wb_err` input 1: slave responses.
- `grant_idx` output `GW=max(1,$clog2(N))`: current owner, for debug/trace.

## Operation
- FSM states are IDLE and BUSY. Registers are `state`, `grant_idx`, `last_idx`, and `tmo_cnt`.
- **IDLE:**
  - If any `m_wb_cyc[i]` is set, pick the first requester scanning from `last_idx+1` upward, modulo N.
  - Register the pick into `grant_idx` and `last_idx`, then go to BUSY.
  - If there are no requests, stay in IDLE.
- **BUSY:**
  - Slave outputs mux combinationally from master `grant_idx`.
  - `s_wb_ack` routes to `m_wb_ack[grant_idx]` only. `s_wb_err` routes to `m_wb_err[grant_idx]` only. All other `m_wb_ack`/`m_wb_err` bits are 0.
  - Ownership is locked while `m_wb_cyc[grant_idx]` stays high, across any number of `stb` beats.
  - When `m_wb_cyc[grant_idx]` falls, `s_wb_cyc`/`s_wb_stb` drop in the same cycle (combinational) and the FSM returns to IDLE on the next edge.
- **IDLE outputs:** `s_wb_cyc`=`s_wb_stb`=`s_wb_we`=0; `s_wb_adr`/`s_wb_datwr`/`s_wb_sel` = master 0 values, don't-care; all `m_wb_ack`/`m_wb_err` = 0.
- **Timeout** (only when `TIMEOUT_CYCLES`>0):
  - In BUSY, `tmo_cnt` increments each cycle that `s_wb_stb`=1 and `s_wb_ack`=`s_wb_err`=0. It clears otherwise.
  - When `tmo_cnt`==`TIMEOUT_CYCLES`, that cycle forces `m_wb_err[grant_idx]`=1, forces `s_wb_stb`=0, and clears `tmo_cnt`.
  - The master then terminates or retries; the arbiter stays in BUSY.
- **Simultaneous slave `ack` and `err`:** `err` wins, so `ack` is masked to 0.
- **Counter width:** `tmo_cnt` is `$clog2(TIMEOUT_CYCLES+1)` bits. It saturates logically at the compare and never wraps.
- **N=1:** the arbiter degenerates to a pass-through with a one-cycle grant latency and the timeout still active.

## Timing
- **Reset values:**
  - `state`=IDLE, `grant_idx`=0, `last_idx`=N-1, so master 0 wins first, and `tmo_cnt`=0.
  - All `s_wb_*` controls are 0 and all `m_wb_ack`/`m_wb_err` are 0.
- **Reset assertion mid-cycle:** outputs go to reset values immediately (asynchronous) and the in-flight transfer is abandoned without ack.
- **Grant latency:** one cycle. A request seen at edge k appears on `s_wb_cyc`/`s_wb_stb` after edge k+1.
- **Response path:** `s_wb_ack`/`s_wb_err`/`s_wb_datrd` to the master outputs is combinational, zero cycles.
- **Release gap:** at least one IDLE cycle between ownerships. Back-to-back grants to different masters are therefore separated by 1 cycle.
- **Fairness:** with all N masters continuously requesting, each master is granted once per N ownerships.

## Structure
- Package `wb_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, BUSY);
  - the grant-index and timeout-counter width helper functions.
- Sub-module `wb_rr_picker` is purely combinational. Its inputs are `req[N]` and `last_idx`; its outputs are `valid` and `pick_idx`. It is implemented as a double-width rotate plus priority encode.
- The top level holds the FSM, the timeout counter, and the output muxes.

## Test plan
- **Single master read:** N=2, m0 asserts cyc/stb/adr=0x10, slave acks 1 cycle later with datrd=0xDEADBEEF → `s_wb_stb` rises 1 cycle after request; `m_wb_ack[0]` pulses with `m_wb_datrd`=0xDEADBEEF; `m_wb_ack[1]`=0.
- **Round-robin:** N=3, all masters hold cyc continuously and each drops cyc after one acked beat → grant order 0,1,2,0,1,2 with one IDLE cycle between grants.
- **Locked burst:** m1 holds cyc across 4 stb beats while m0 requests → m0 is not granted until m1 drops cyc; m0 is granted exactly 2 cycles after the drop.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never responds → `m_wb_err[grant]` pulses on the 9th stalled cycle with `s_wb_stb`=0 that cycle; the count restarts afterwards.
- **Slave err and ack collision:** slave asserts ack and err together → `m_wb_err`=1 and `m_wb_ack`=0 for the granted master.
- **Async reset mid-transfer:** reset pulled low while BUSY with stb high → `s_wb_cyc`/`s_wb_stb` go to 0 before the next clock edge; after release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int gidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tmo_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester after last_idx, modulo N.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_idx,
    output logic          valid,
    output logic [GW-1:0] pick_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             start;

    // Rotating the doubled vector puts last_idx+1 at bit 0.
    always_comb begin
        dbl      = {req, req};
        start    = (int'(last_idx) + 1) % N;
        rot      = N'(dbl >> start);
        valid    = |req;
        pick_idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_idx = GW'((start + j) % N);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter: round-robin grant,
// cycle locking and a bus-timeout error path.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int N  = NUM_MASTERS,
    localparam int GW = gidx_w(NUM_MASTERS),
    localparam int TW = tmo_w(TIMEOUT_CYCLES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N*ADDR_WIDTH-1:0] m_wb_adr,
    input  logic [N*DATA_WIDTH-1:0] m_wb_datwr,
    input  logic [N-1:0]            m_wb_we,
    input  logic [N-1:0]            m_wb_stb,
    input  logic [N-1:0]            m_wb_cyc,
    input  logic [N*SEL_WIDTH-1:0]  m_wb_sel,
    output logic [DATA_WIDTH-1:0]   m_wb_datrd,
    output logic [N-1:0]            m_wb_ack,
    output logic [N-1:0]            m_wb_err,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr,
    output logic [DATA_WIDTH-1:0]   s_wb_datwr,
    output logic                    s_wb_we,
    output logic                    s_wb_stb,
    output logic                    s_wb_cyc,
    output logic [SEL_WIDTH-1:0]    s_wb_sel,
    input  logic [DATA_WIDTH-1:0]   s_wb_datrd,
    input  logic                    s_wb_ack,
    input  logic                    s_wb_err,
    output logic [GW-1:0]           grant_idx
);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [GW-1:0] sel_idx;
    logic          busy, cyc_g, raw_stb;
    logic          hit, ack_g, err_g;

    logic [ADDR_WIDTH-1:0] adr_a [N];
    logic [DATA_WIDTH-1:0] dat_a [N];
    logic [SEL_WIDTH-1:0]  sel_a [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign adr_a[i] = m_wb_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_a[i] = m_wb_datwr[i*DATA_WIDTH +: DATA_WIDTH];
        assign sel_a[i] = m_wb_sel[i*SEL_WIDTH +: SEL_WIDTH];
    end

    wb_rr_picker #(
        .N  (N),
        .GW (GW)
    ) u_pick (
        .req      (m_wb_cyc),
        .last_idx (last_q),
        .valid    (pick_vld),
        .pick_idx (pick)
    );

    always_comb begin
        busy    = (state_q == BUSY);
        sel_idx = busy ? grant_q : '0;
        cyc_g   = busy && m_wb_cyc[sel_idx];
        raw_stb = cyc_g && m_wb_stb[sel_idx];
        hit     = (TIMEOUT_CYCLES > 0) && raw_stb &&
                  (tmo_q == TW'(TIMEOUT_CYCLES));

        s_wb_cyc   = cyc_g;
        s_wb_stb   = raw_stb && !hit;
        s_wb_we    = cyc_g && m_wb_we[sel_idx];
        s_wb_adr   = adr_a[sel_idx];
        s_wb_datwr = dat_a[sel_idx];
        s_wb_sel   = sel_a[sel_idx];

        // A slave err (or forced timeout) always masks a coincident ack.
        err_g = busy && (s_wb_err || hit);
        ack_g = busy && s_wb_ack && !err_g;

        m_wb_ack          = '0;
        m_wb_err          = '0;
        m_wb_ack[sel_idx] = ack_g;
        m_wb_err[sel_idx] = err_g;
        m_wb_datrd        = s_wb_datrd;
        grant_idx         = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    grant_d = pick;
                    last_d  = pick;
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                end
                if ((TIMEOUT_CYCLES > 0) && s_wb_stb &&
                    !s_wb_ack && !s_wb_err) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
